reg_writeback: RTL and testbench
================================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001: Parameter BUF_DEPTH, default 2: number of load-result buffer entries, legal range 1..4.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: aluValid  input  1  ALU result present this cycle; always accepted, no back-pressure.
REQ-005: aluReg  input  5  ALU destination register index.
REQ-006: aluData  input  32  ALU result value.
REQ-007: memValid  input  1  load result offered.
REQ-008: memReady  output  1  load result accepted this cycle when high together with memValid.
REQ-009: memReg  input  5  load destination register index.
REQ-010: memData  input  32  load result value.
REQ-011: wrData  output  32  registered write data to register file.
REQ-012: wrReg  output  5  registered write index to register file.
REQ-013: writeEnable  output  1  registered write strobe to register file.
REQ-014: pendingMask  output  32  bit r high when a write to register r is buffered or on the output port.

Function
REQ-015: Mem transfer SHALL occur on a cycle with memValid=1 and memReady=1; no transfer otherwise, memReg/memData ignored.
REQ-016: memReady SHALL be 1 exactly when the buffer count < BUF_DEPTH and rst=0, derived from registered state only, not from memValid.
REQ-017: Output selection each cycle, in priority order: aluValid=1 -> ALU result; else buffer non-empty -> buffer head (popped); else mem transfer -> mem result directly (bypass, not buffered); else no write.
REQ-018: A mem transfer not taken by bypass SHALL be pushed at the buffer tail in the same edge; simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-019: Load results SHALL reach the output in acceptance order; ALU results SHALL never be delayed.
REQ-020: Selected result SHALL appear on wrReg/wrData/writeEnable at the next rising edge (1-cycle latency) and be held for exactly one cycle.
REQ-021: When no result is selected, writeEnable SHALL be 0 and wrReg/wrData SHALL hold their previous values.
REQ-022: Writes targeting register 0 SHALL be discarded: ALU result with aluReg=0 gives writeEnable=0 that cycle; mem transfer with memReg=0 is accepted and neither pushed nor bypassed, and does not block a lower-priority selection.
REQ-023: With buffer full and aluValid=1, memReady SHALL be 0; the head is not popped; count stays BUF_DEPTH.
REQ-024: Buffer pointers SHALL wrap modulo BUF_DEPTH; count range 0..BUF_DEPTH, never overflow or underflow.
REQ-025: pendingMask SHALL be the OR of one-hot(index) over all valid buffer entries and one-hot(wrReg) when writeEnable=1; bit 0 SHALL always be 0.
REQ-026: Same-index conflicts between ALU and buffered loads are not reordered; the decoder uses pendingMask to stall.

Reset
REQ-027: With rst=1 at an edge: writeEnable=0, wrReg=0, wrData=0, buffer count=0, pointers=0, pendingMask=0.
REQ-028: memReady SHALL be 0 while rst=1; inputs during rst are dropped; reset mid-operation discards all buffered entries.
REQ-029: First write after reset deassertion SHALL be possible on the cycle after rst falls.

Verification
REQ-030: Reset, then aluValid=1, aluReg=5, aluData=80 for one cycle -> next cycle writeEnable=1, wrReg=5, wrData=80; following cycle writeEnable=0.
REQ-031: memValid=1, memReg=7, memData=112, buffer empty, aluValid=0 -> memReady=1, next cycle wrReg=7, wrData=112, writeEnable=1, count remains 0.
REQ-032: aluValid and memValid together for 3 cycles (ALU regs 1,2,3; mem regs 9,10,11; BUF_DEPTH=2) -> ALU writes 1,2,3 on consecutive cycles; memReady=0 on 3rd cycle; then mem writes 9,10 in order; reg 11 accepted only after retry; pendingMask bit9 and bit10 high while buffered.
REQ-033: aluReg=0 aluData=0xFFFFFFFF and memReg=0 -> writeEnable stays 0, pendingMask=0, memReady stays 1.
REQ-034: Buffer full (two entries), rst=1 for one cycle -> count=0, writeEnable=0, pendingMask=0; buffered entries never written.
REQ-035: Connected to the register file: write regs 1..31 with data 16*index via alternating ALU/mem sources, then read all -> REG[i]=16*i, REG[0]=0.

Source files
------------

// File: rtl/reg_writeback.sv
// Writeback stage: merges ALU results and load results into one register-file write port.
// Loads that lose arbitration wait in a small FIFO; ALU results always win and are never delayed.
module reg_writeback #(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aluValid,
    input  logic [4:0]  aluReg,
    input  logic [31:0] aluData,
    input  logic        memValid,
    output logic        memReady,
    input  logic [4:0]  memReg,
    input  logic [31:0] memData,
    output logic [31:0] wrData,
    output logic [4:0]  wrReg,
    output logic        writeEnable,
    output logic [31:0] pendingMask
);

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W    = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [SUM_W-1:0] WRAP_SUM = SUM_W'(BUF_DEPTH);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [REG_W-1:0]  buf_reg_q  [BUF_DEPTH];
    logic [REG_W-1:0]  buf_reg_d  [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data_d [BUF_DEPTH];

    logic              wr_en_q, wr_en_d;
    logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              mem_xfer;
    logic              mem_keep;
    logic              push;
    logic              pop;
    logic [NUM_REGS-1:0] pend_mask;
    logic [SUM_W-1:0]  slot_sum;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Readiness depends only on the occupancy register, never on memValid.
    assign memReady = ~rst & (count_q < FULL_CNT);

    assign mem_xfer = memValid & memReady;
    assign mem_keep = mem_xfer & (memReg != '0);

    // Priority select: ALU, then buffered load, then direct load bypass.
    always_comb begin
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        buf_reg_d  = buf_reg_q;
        buf_data_d = buf_data_q;
        wr_en_d    = 1'b0;
        wr_reg_d   = wr_reg_q;
        wr_data_d  = wr_data_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (aluValid) begin
            if (aluReg != '0) begin
                wr_en_d   = 1'b1;
                wr_reg_d  = aluReg;
                wr_data_d = aluData;
            end
            push = mem_keep;
        end else if (count_q != '0) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = buf_reg_q[head_q];
            wr_data_d = buf_data_q[head_q];
            pop       = 1'b1;
            push      = mem_keep;
        end else if (mem_keep) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = memReg;
            wr_data_d = memData;
        end

        if (push) begin
            buf_reg_d[tail_q]  = memReg;
            buf_data_d[tail_q] = memData;
            tail_d             = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Hazard mask: every destination still buffered plus the one on the port.
    always_comb begin
        pend_mask = '0;
        slot_sum  = '0;
        if (wr_en_q) begin
            pend_mask[wr_reg_q] = 1'b1;
        end
        for (int k = 0; k < int'(BUF_DEPTH); k++) begin
            if (CNT_W'(k) < count_q) begin
                slot_sum = {1'b0, head_q} + SUM_W'(k);
                if (slot_sum >= WRAP_SUM) begin
                    slot_sum = slot_sum - WRAP_SUM;
                end
                pend_mask[buf_reg_q[slot_sum[PTR_W-1:0]]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        buf_reg_q  <= buf_reg_d;
        buf_data_q <= buf_data_d;
    end

    assign writeEnable = wr_en_q;
    assign wrReg       = wr_reg_q;
    assign wrData      = wr_data_q;
    assign pendingMask = pend_mask;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: queue-based reference model feeds an expected-write scoreboard
// drained by an independent output monitor.
module tb_reg_writeback;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        aluValid;
    logic [4:0]  aluReg;
    logic [31:0] aluData;
    logic        memValid;
    logic        memReady;
    logic [4:0]  memReg;
    logic [31:0] memData;
    logic [31:0] wrData;
    logic [4:0]  wrReg;
    logic        writeEnable;
    logic [31:0] pendingMask;

    always #5 clk = ~clk;

    reg_writeback #(.BUF_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluValid    (aluValid),
        .aluReg      (aluReg),
        .aluData     (aluData),
        .memValid    (memValid),
        .memReady    (memReady),
        .memReg      (memReg),
        .memData     (memData),
        .wrData      (wrData),
        .wrReg       (wrReg),
        .writeEnable (writeEnable),
        .pendingMask (pendingMask)
    );

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        int          c;
    } exp_t;

    ent_t        mbuf[$];
    exp_t        exp_q[$];
    logic        m_we   = 1'b0;
    logic [4:0]  m_reg  = '0;
    logic [31:0] m_data = '0;
    logic [31:0] rf [32];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        mon_x;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One cycle: drive inputs, check state-derived outputs, advance the reference model.
    task automatic step(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        output logic accepted);
        logic        exp_ready;
        logic [31:0] exp_mask;
        logic        keep;
        logic        have;
        logic [4:0]  wr;
        logic [31:0] wd;
        ent_t        e;
        rst = r; aluValid = av; aluReg = ar; aluData = ad;
        memValid = mv; memReg = mr; memData = md;
        #1;
        exp_ready = !r && (mbuf.size() < DEPTH);
        exp_mask  = '0;
        foreach (mbuf[i]) exp_mask[mbuf[i].r] = 1'b1;
        if (m_we) exp_mask[m_reg] = 1'b1;
        exp_mask[0] = 1'b0;
        check32("memReady", 32'(memReady), 32'(exp_ready));
        check32("pendingMask", pendingMask, exp_mask);
        check32("wrReg_hold", 32'(wrReg), 32'(m_reg));
        check32("wrData_hold", wrData, m_data);

        accepted = mv && exp_ready;
        keep     = accepted && (mr != 5'd0);
        have     = 1'b0;
        wr       = '0;
        wd       = '0;
        if (r) begin
            mbuf.delete();
            m_we = 1'b0; m_reg = '0; m_data = '0;
        end else begin
            if (av) begin
                if (ar != 5'd0) begin have = 1'b1; wr = ar; wd = ad; end
                if (keep) mbuf.push_back('{mr, md});
            end else if (mbuf.size() > 0) begin
                e = mbuf.pop_front();
                have = 1'b1; wr = e.r; wd = e.d;
                if (keep) mbuf.push_back('{mr, md});
            end else if (keep) begin
                have = 1'b1; wr = mr; wd = md;
            end
            m_we = have;
            if (have) begin
                m_reg = wr; m_data = wd;
                exp_q.push_back('{wr, wd, cyc + 1});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    endtask

    // Output monitor: every write strobe must match the oldest expected write, on its cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            n_checks++; n_fail++;
            $display("FAIL missed_write: reg %0d data %h due cycle %0d, no matching write observed", exp_q[0].r, exp_q[0].d, exp_q[0].c);
            void'(exp_q.pop_front());
        end
        if (writeEnable === 1'b1) begin
            rf[wrReg] = wrData;
            n_checks++;
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                mon_x = exp_q.pop_front();
                if (wrReg !== mon_x.r || wrData !== mon_x.d) begin
                    n_fail++;
                    $display("FAIL write_value at cycle %0d: got reg %0d data %h expected reg %0d data %h",
                             cyc, wrReg, wrData, mon_x.r, mon_x.d);
                end
            end else begin
                n_fail++;
                $display("FAIL unexpected_write at cycle %0d: got reg %0d data %h expected no write", cyc, wrReg, wrData);
            end
        end else if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
            n_checks++; n_fail++;
            mon_x = exp_q.pop_front();
            $display("FAIL no_write at cycle %0d: got writeEnable %b expected reg %0d data %h", cyc, writeEnable, mon_x.r, mon_x.d);
        end
    end

    initial begin
        logic        acc;
        logic        av, mv, r;
        logic [4:0]  ar, mr;
        int          tries;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst = 1'b1; aluValid = 1'b0; aluReg = '0; aluData = '0;
        memValid = 1'b0; memReg = '0; memData = '0;
        @(negedge clk);

        // Reset state, then a single ALU write.
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
        step(1'b0, 1'b1, 5'd5, 32'd80, 1'b0, 5'd0, 32'd0, acc);
        idle(2);

        // Load bypass with an empty buffer.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd112, acc);
        idle(2);

        // ALU and loads contending: loads buffer, third load stalls and retries.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'(i + 1), 32'(100 + i), 1'b1, 5'(9 + i), 32'(900 + i), acc);
        tries = 0;
        do begin
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'd902, acc);
            tries++;
        end while (!acc && tries < 10);
        check32("retry_accept", 32'(acc), 32'd1);
        idle(3);

        // Register-zero writes from both sources are dropped.
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hDEAD_BEEF, acc);
        idle(2);

        // Fill the buffer, then reset: buffered loads must never appear.
        step(1'b0, 1'b1, 5'd3, 32'd33, 1'b1, 5'd20, 32'd2020, acc);
        step(1'b0, 1'b1, 5'd4, 32'd44, 1'b1, 5'd21, 32'd2121, acc);
        step(1'b1, 1'b1, 5'd6, 32'd66, 1'b1, 5'd22, 32'd2222, acc);
        idle(4);

        // Register-file image: regs 1..31 written from alternating sources.
        for (int i = 0; i < 32; i++) rf[i] = '0;
        for (int i = 1; i < 32; i++) begin
            if (i % 2 == 1) step(1'b0, 1'b1, 5'(i), 32'(16 * i), 1'b0, 5'd0, 32'd0, acc);
            else            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(16 * i), acc);
        end
        idle(3);
        for (int i = 0; i < 32; i++) check32($sformatf("regfile_%0d", i), rf[i], 32'(16 * i));

        // Randomized traffic with occasional mid-stream resets.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 59) == 0);
            av = 1'($urandom_range(0, 1));
            mv = ($urandom_range(0, 9) < 6);
            ar = 5'($urandom_range(1, 31));
            mr = 5'($urandom_range(0, 31));
            if (av && !mv && mbuf.size() == 0 && $urandom_range(0, 7) == 0) ar = 5'd0;
            step(r, av, ar, $urandom, mv, mr, $urandom, acc);
        end

        idle(8);
        check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
